// File: rtl/mvm_stream_engine.sv
// mvm_stream_engine
// Streams a ROWSxCOLS signed matrix M (row-major) followed by a COLS-element
// vector X through one valid/ready input, computes Y = M*X with a single
// signed MAC per cycle, and streams the ROWS results out through a
// valid/ready output.
//
// Handshake semantics (both ports): a word transfers on a rising clk edge
// where valid && ready are both high. A producer holds data stable while
// valid is high and ready is low. The engine never withdraws m_valid before
// it is accepted, and s_ready depends only on the FSM state.
//
// Optional feature macro: MVM_RELU_EN. When defined, a negative result is
// clamped to zero as it is registered into data_out.
module mvm_stream_engine #(
   parameter int ROWS  = 3,
   parameter int COLS  = 3,
   parameter int DW    = 8,
   parameter int ACC_W = 2*DW + $clog2(COLS+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DW-1:0]    data_in,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             keep_m,
   input  logic             clr_acc,
   output logic [ACC_W-1:0] data_out,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             frame_done
);

   localparam int IDX_W = (ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

   localparam logic [IDX_W-1:0] LAST_M   = IDX_W'(ROWS*COLS-1);
   localparam logic [IDX_W-1:0] LAST_X   = IDX_W'(COLS-1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS-1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS-1);

   typedef enum logic [1:0] {
      ST_LOAD_M = 2'd0,
      ST_LOAD_X = 2'd1,
      ST_MAC    = 2'd2,
      ST_OUT    = 2'd3
   } state_t;

   state_t state, state_nxt;

   // Operand storage; contents survive reset and aborts by design.
   logic signed [DW-1:0] m_mem [ROWS*COLS];
   logic signed [DW-1:0] x_mem [COLS];

   logic [IDX_W-1:0] idx;       // load position for M or X
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic             m_loaded;  // a complete M has been stored since reset/abort

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] result;
   logic signed [2*DW-1:0]  prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [DW-1:0]    m_rd;
   logic signed [DW-1:0]    x_rd;
   logic [IDX_W-1:0]        m_addr;

   logic s_accept;
   logic m_accept;

   // Handshake qualifiers and next-state selection; clr_acc overrides everything.
   always_comb begin
      state_nxt  = state;
      s_ready    = (state == ST_LOAD_M) || (state == ST_LOAD_X);
      s_accept   = s_valid && s_ready && !clr_acc;
      m_accept   = m_valid && m_ready && !clr_acc;
      frame_done = m_accept && (state == ST_OUT) && (row == LAST_ROW);
      case (state)
         ST_LOAD_M: if (s_accept && idx == LAST_M) state_nxt = ST_LOAD_X;
         ST_LOAD_X: if (s_accept && idx == LAST_X) state_nxt = ST_MAC;
         ST_MAC:    if (col == LAST_COL)           state_nxt = ST_OUT;
         ST_OUT: begin
            if (m_accept) begin
               if (row != LAST_ROW)
                  state_nxt = ST_MAC;
               else if (keep_m && m_loaded)
                  state_nxt = ST_LOAD_X;
               else
                  state_nxt = ST_LOAD_M;
            end
         end
         default:   state_nxt = ST_LOAD_M;
      endcase
      if (clr_acc) state_nxt = ST_LOAD_M;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_LOAD_M;
      else       state <= state_nxt;
   end

   // MAC operand fetch and signed product, sign-extended to the accumulator width.
   always_comb begin
      m_addr   = IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
      m_rd     = m_mem[m_addr];
      x_rd     = x_mem[col];
      prod     = m_rd * x_rd;
      prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
      sum      = (col == '0) ? prod_ext : acc + prod_ext;
`ifdef MVM_RELU_EN
      result   = sum[ACC_W-1] ? '0 : sum;
`else
      result   = sum;
`endif
   end

   // Operand writes for accepted input words.
   always_ff @(posedge clk) begin
      if (s_accept) begin
         if (state == ST_LOAD_M) m_mem[idx] <= data_in;
         else                    x_mem[idx[COL_W-1:0]] <= data_in;
      end
   end

   // Counters, accumulator and output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx      <= '0;
         row      <= '0;
         col      <= '0;
         acc      <= '0;
         data_out <= '0;
         m_valid  <= 1'b0;
         m_loaded <= 1'b0;
      end else if (clr_acc) begin
         idx      <= '0;
         row      <= '0;
         col      <= '0;
         m_valid  <= 1'b0;
         m_loaded <= 1'b0;
      end else begin
         case (state)
            ST_LOAD_M: begin
               if (s_accept) begin
                  if (idx == LAST_M) begin
                     idx      <= '0;
                     m_loaded <= 1'b1;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            ST_LOAD_X: begin
               if (s_accept) begin
                  if (idx == LAST_X) begin
                     idx <= '0;
                     row <= '0;
                     col <= '0;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            ST_MAC: begin
               acc <= sum;
               if (col == LAST_COL) begin
                  col      <= '0;
                  data_out <= result;
                  m_valid  <= 1'b1;
               end else begin
                  col <= col + COL_W'(1);
               end
            end
            ST_OUT: begin
               if (m_accept) begin
                  m_valid <= 1'b0;
                  if (row == LAST_ROW) row <= '0;
                  else                 row <= row + ROW_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
